// File: rtl/io_bus_master.sv
// ---------------------------------------------------------------------------
// io_bus_master : Sextium III I/O strobe-bus master (level strobes, ack, gap)
// Optional IO_TIMEOUT_EN adds an ack timeout.          Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module io_bus_master #(
  parameter int GAP_CYCLES = 1,
  parameter int TIMEOUT    = 1024,
  parameter int TO_W       = 11
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req_read,
  input  logic        cpu_req_write,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_done,
  output logic        cpu_error,
  output logic        cpu_busy,
  output logic        io_read,
  output logic        io_write,
  input  logic        ioack,
  input  logic [15:0] data_in,
  output logic [15:0] data_out
);

  // A zero-length gap would let the device miss a strobe edge, so clamp to 1.
  localparam int c_gap_eff = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
  localparam int c_gw      = (c_gap_eff > 1) ? $clog2(c_gap_eff) : 1;
  localparam logic [c_gw-1:0] c_gap_last = c_gw'(c_gap_eff - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t            r_state, w_state;
  logic [c_gw-1:0]   r_gap_cnt, w_gap_cnt;
  logic [15:0]       r_rdata, w_rdata;
  logic [15:0]       r_dout, w_dout;
  logic              r_done, w_done;
  logic              r_busy, w_busy;
  logic              r_rd, w_rd;
  logic              r_wr, w_wr;

`ifdef IO_TIMEOUT_EN
  localparam logic [TO_W-1:0] c_to_last = TO_W'(TIMEOUT - 1);
  logic [TO_W-1:0]   r_to_cnt, w_to_cnt;
  logic              r_err, w_err;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_gap_cnt <= '0;
      r_rdata   <= '0;
      r_dout    <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
`ifdef IO_TIMEOUT_EN
      r_to_cnt  <= '0;
      r_err     <= 1'b0;
`endif
    end else begin
      r_state   <= w_state;
      r_gap_cnt <= w_gap_cnt;
      r_rdata   <= w_rdata;
      r_dout    <= w_dout;
      r_done    <= w_done;
      r_busy    <= w_busy;
      r_rd      <= w_rd;
      r_wr      <= w_wr;
`ifdef IO_TIMEOUT_EN
      r_to_cnt  <= w_to_cnt;
      r_err     <= w_err;
`endif
    end
  end

  always_comb begin
    w_state   = r_state;
    w_gap_cnt = r_gap_cnt;
    w_rdata   = r_rdata;
    w_dout    = r_dout;
    w_done    = 1'b0;
    w_rd      = r_rd;
    w_wr      = r_wr;
`ifdef IO_TIMEOUT_EN
    w_to_cnt  = r_to_cnt;
    w_err     = r_err;
`endif
    case (r_state)
      S_IDLE: begin
        // Read has priority; a simultaneous write is dropped.
        if (cpu_req_read) begin
          w_state = S_RD;
          w_rd    = 1'b1;
`ifdef IO_TIMEOUT_EN
          w_err    = 1'b0;
          w_to_cnt = '0;
`endif
        end else if (cpu_req_write) begin
          w_state = S_WR;
          w_wr    = 1'b1;
          w_dout  = cpu_wdata;
`ifdef IO_TIMEOUT_EN
          w_err    = 1'b0;
          w_to_cnt = '0;
`endif
        end
      end
      S_RD: begin
        if (ioack) begin
          w_rdata   = data_in;
          w_rd      = 1'b0;
          w_done    = 1'b1;
          w_state   = S_GAP;
          w_gap_cnt = '0;
        end
`ifdef IO_TIMEOUT_EN
        else if (r_to_cnt == c_to_last) begin
          w_rd      = 1'b0;
          w_done    = 1'b1;
          w_err     = 1'b1;
          w_state   = S_GAP;
          w_gap_cnt = '0;
        end else begin
          w_to_cnt = r_to_cnt + 1'b1;
        end
`endif
      end
      S_WR: begin
        if (ioack) begin
          w_wr      = 1'b0;
          w_done    = 1'b1;
          w_state   = S_GAP;
          w_gap_cnt = '0;
        end
`ifdef IO_TIMEOUT_EN
        else if (r_to_cnt == c_to_last) begin
          w_wr      = 1'b0;
          w_done    = 1'b1;
          w_err     = 1'b1;
          w_state   = S_GAP;
          w_gap_cnt = '0;
        end else begin
          w_to_cnt = r_to_cnt + 1'b1;
        end
`endif
      end
      S_GAP: begin
        if (r_gap_cnt == c_gap_last) begin
          w_state = S_IDLE;
        end else begin
          w_gap_cnt = r_gap_cnt + 1'b1;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_rd    = 1'b0;
        w_wr    = 1'b0;
      end
    endcase
    w_busy = (w_state != S_IDLE);
  end

  assign cpu_rdata = r_rdata;
  assign cpu_done  = r_done;
  assign cpu_busy  = r_busy;
  assign io_read   = r_rd;
  assign io_write  = r_wr;
  assign data_out  = r_dout;

`ifdef IO_TIMEOUT_EN
  assign cpu_error = r_err;
`else
  assign cpu_error = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_io_bus_master.sv
// Testbench for io_bus_master: table-driven transactions, scoreboard on cpu_done.
`default_nettype none

module tb_io_bus_master;

  localparam int GAP = 2;
  localparam int TMO = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req_read = 1'b0;
  logic        cpu_req_write = 1'b0;
  logic [15:0] cpu_wdata = 16'h0;
  logic [15:0] cpu_rdata;
  logic        cpu_done, cpu_error, cpu_busy;
  logic        io_read, io_write;
  logic        ioack;
  logic [15:0] data_in;
  logic [15:0] data_out;

  always #5 clock = ~clock;

  io_bus_master #(.GAP_CYCLES(GAP), .TIMEOUT(TMO), .TO_W(4)) dut (
    .clock(clock), .reset(reset),
    .cpu_req_read(cpu_req_read), .cpu_req_write(cpu_req_write),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_done(cpu_done), .cpu_error(cpu_error), .cpu_busy(cpu_busy),
    .io_read(io_read), .io_write(io_write), .ioack(ioack),
    .data_in(data_in), .data_out(data_out)
  );

  // Device model: acks after dev_delay strobe cycles.
  int          dev_delay = 0;
  logic        dev_ack_en = 1'b1;
  logic        ack_force = 1'b1;
  logic        b2b = 1'b0;
  logic [15:0] dev_val = 16'h0;
  int          hi_cnt = 0;
  int          rd_rises = 0, wr_rises = 0, rd_base = 0;

  always @(posedge clock) hi_cnt <= (io_read || io_write) ? hi_cnt + 1 : 0;
  assign ioack   = ack_force || (dev_ack_en && (io_read || io_write) && (hi_cnt >= dev_delay));
  assign data_in = b2b ? 16'(rd_rises - rd_base) : dev_val;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] rdata;
    logic        err;
  } exp_t;
  exp_t q[$];

  int   n_done = 0, run = 0, last_w = 0, rd_low = 0, min_low = 1000;
  int   bl = 0, last_bl = 0;
  logic busy_track = 1'b0, seen_rd = 1'b0;
  logic prev_rd = 1'b0, prev_wr = 1'b0, prev_done = 1'b0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (io_read && io_write) chk("strobe_excl", 1, 0);
        if (io_read && !prev_rd) rd_rises++;
        if (io_write && !prev_wr) wr_rises++;
        if (io_read) begin
          if (!prev_rd && seen_rd && rd_low < min_low) min_low = rd_low;
          rd_low  = 0;
          seen_rd = 1'b1;
        end else begin
          rd_low++;
        end
        if (io_read || io_write) run++;
        else if (run != 0) begin
          last_w = run;
          run    = 0;
        end
        if (busy_track) begin
          bl++;
          if (!cpu_busy) begin
            last_bl    = bl;
            busy_track = 1'b0;
          end
        end
        if (cpu_done) begin
          if (prev_done) chk("done_twice", 1, 0);
          if (q.size() == 0) chk("unexpected_done", 1, 0);
          else begin
            e = q.pop_front();
            chk("rdata", 32'(cpu_rdata), 32'(e.rdata));
            chk("error", 32'(cpu_error), 32'(e.err));
          end
          n_done++;
          busy_track = 1'b1;
          bl         = 0;
        end
        prev_rd   = io_read;
        prev_wr   = io_write;
        prev_done = cpu_done;
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (cpu_busy && k < 200) begin
      @(negedge clock); #1;
      k++;
    end
    if (cpu_busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic wait_done(input int target);
    int k = 0;
    while (n_done < target && k < 2000) begin
      @(negedge clock); #1;
      k++;
    end
    if (n_done < target) chk("done_timeout", 32'(n_done), 32'(target));
  endtask

  task automatic pulse_req(input logic rd, input logic wr, input logic [15:0] wd);
    @(posedge clock); #1;
    cpu_req_read  = rd;
    cpu_req_write = wr;
    cpu_wdata     = wd;
    @(posedge clock); #1;
    cpu_req_read  = 1'b0;
    cpu_req_write = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] wdata;
    logic [15:0] val;
    int          dly;
    logic [15:0] exp_rdata;
    logic [15:0] exp_dout;
    int          exp_w;
    logic        exp_rd;
  } vec_t;

  vec_t v[5];

  initial begin
    int r0, w0, d0;
    v[0] = '{1'b1, 1'b0, 16'h0000, 16'h1234, 0, 16'h1234, 16'h0000, 1, 1'b1};
    v[1] = '{1'b0, 1'b1, 16'hBEEF, 16'h0000, 5, 16'h1234, 16'hBEEF, 6, 1'b0};
    v[2] = '{1'b1, 1'b1, 16'h00FF, 16'h5A5A, 0, 16'h5A5A, 16'hBEEF, 1, 1'b1};
    v[3] = '{1'b1, 1'b0, 16'h0000, 16'h0007, 2, 16'h0007, 16'hBEEF, 3, 1'b1};
    v[4] = '{1'b0, 1'b1, 16'hC3C3, 16'hFFFF, 1, 16'h0007, 16'hC3C3, 2, 1'b0};

    // Reset with both requests and ack forced high.
    cpu_req_read  = 1'b1;
    cpu_req_write = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("rst_ctrl", {27'b0, io_read, io_write, cpu_done, cpu_error, cpu_busy}, 0);
      chk("rst_data", {cpu_rdata, data_out}, 0);
    end
    @(posedge clock); #1;
    reset         = 1'b0;
    cpu_req_read  = 1'b0;
    cpu_req_write = 1'b0;
    ack_force     = 1'b0;

    for (int i = 0; i < 5; i++) begin
      wait_idle();
      dev_val   = v[i].val;
      dev_delay = v[i].dly;
      r0 = rd_rises; w0 = wr_rises; d0 = n_done;
      q.push_back('{v[i].exp_rdata, 1'b0});
      pulse_req(v[i].rd, v[i].wr, v[i].wdata);
      wait_done(d0 + 1);
      chk("strobe_width", 32'(last_w), 32'(v[i].exp_w));
      chk("rd_pulses", 32'(rd_rises - r0), 32'(v[i].exp_rd));
      chk("wr_pulses", 32'(wr_rises - w0), 32'(!v[i].exp_rd));
      chk("data_out", 32'(data_out), 32'(v[i].exp_dout));
      wait_idle();
      chk("busy_after_done", 32'(last_bl), 32'(GAP));
    end

    // Ack while idle must be ignored.
    d0 = n_done; r0 = rd_rises; w0 = wr_rises;
    ack_force = 1'b1;
    repeat (4) @(posedge clock);
    #1 ack_force = 1'b0;
    chk("idle_ack_done", 32'(n_done), 32'(d0));
    chk("idle_ack_strobe", 32'(rd_rises + wr_rises), 32'(r0 + w0));

    // Back-to-back read requests held every cycle: three accepted.
    wait_idle();
    min_low = 1000;
    seen_rd = 1'b0;
    rd_base = rd_rises;
    b2b = 1'b1;
    dev_delay = 0;
    q.push_back('{16'h0001, 1'b0});
    q.push_back('{16'h0002, 1'b0});
    q.push_back('{16'h0003, 1'b0});
    d0 = n_done;
    @(posedge clock); #1 cpu_req_read = 1'b1;
    repeat (2 * (GAP + 2) + 1) @(posedge clock);
    #1 cpu_req_read = 1'b0;
    wait_done(d0 + 3);
    wait_idle();
    chk("b2b_pulses", 32'(rd_rises - rd_base), 3);
    chk("b2b_gap_ok", 32'(min_low >= GAP), 1);
    chk("b2b_queue_empty", 32'(q.size()), 0);
    b2b = 1'b0;

`ifdef IO_TIMEOUT_EN
    dev_ack_en = 1'b0;
    d0 = n_done;
    q.push_back('{16'h0003, 1'b1});
    pulse_req(1'b1, 1'b0, 16'h0);
    wait_done(d0 + 1);
    chk("timeout_width", 32'(last_w), 32'(TMO));
    wait_idle();
    dev_ack_en = 1'b1;
    dev_val = 16'h4321;
    q.push_back('{16'h4321, 1'b0});
    pulse_req(1'b1, 1'b0, 16'h0);
    wait_done(d0 + 2);
    chk("recover_width", 32'(last_w), 1);
    wait_idle();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
